// File: rtl/panda_mem_load_seq.sv
// Load sequencer feeding the PANDA engine: walks the memory regions in select order,
// requests each non-empty one from the streamer and writes the returned words.
// Optional PANDA_LOAD_SEQ_STALL_EN adds mem_stall_i back-pressure from the accelerator memory.
module panda_mem_load_seq #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 16,
  parameter int unsigned NW   = 16,
  parameter int unsigned NREG = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [NREG*NW-1:0]   region_n_i,
  input  logic [NREG*32-1:0]   region_daddr_i,
  input  logic [NREG*AW-1:0]   region_aaddr_i,
  output logic                 src_req_o,
  output logic [31:0]          src_addr_o,
  output logic [NW-1:0]        src_len_o,
  input  logic [DW-1:0]        data_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
`ifdef PANDA_LOAD_SEQ_STALL_EN
  input  logic                 mem_stall_i,
`endif
  output logic [2:0]           mem_sel_o,
  output logic                 mem_wr_en_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [DW-1:0]        mem_wdata_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned   RW   = $clog2(NREG + 1);
  localparam logic [RW-1:0] LAST = RW'(NREG);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_REQ, S_XFER, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   r_q;
  logic [NW-1:0]   cnt_q, len_q;
  logic [31:0]     daddr_q;
  logic [AW-1:0]   aaddr_q;
  logic [NW-1:0]   cur_n;
  logic [31:0]     cur_daddr;
  logic [AW-1:0]   cur_aaddr;
  logic            stall, beat, last_beat;
  logic            wr_en_q;
  logic [2:0]      wr_sel_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;

`ifdef PANDA_LOAD_SEQ_STALL_EN
  assign stall = mem_stall_i;
`else
  assign stall = 1'b0;
`endif

  // Region r fields; r == NREG selects nothing and is only used for the terminal SCAN.
  always_comb begin
    cur_n     = '0;
    cur_daddr = '0;
    cur_aaddr = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (r_q == RW'(i)) begin
        cur_n     = region_n_i[i*NW +: NW];
        cur_daddr = region_daddr_i[i*32 +: 32];
        cur_aaddr = region_aaddr_i[i*AW +: AW];
      end
    end
  end

  assign beat      = (state_q == S_XFER) && data_valid_i && !stall;
  assign last_beat = beat && (cnt_q == len_q - NW'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      state_q <= S_IDLE;
    else if (clear_i) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_i) state_d = S_SCAN;
      S_SCAN: begin
        if (r_q == LAST)     state_d = S_DONE;
        else if (cur_n != '0) state_d = S_REQ;
      end
      S_REQ:  state_d = S_XFER;
      S_XFER: if (last_beat) state_d = S_SCAN;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    src_req_o    = (state_q == S_REQ);
    src_addr_o   = '0;
    src_len_o    = '0;
    if (state_q == S_REQ || state_q == S_XFER) begin
      src_addr_o = daddr_q;
      src_len_o  = len_q;
    end
    data_ready_o = (state_q == S_XFER) && !stall;
    busy_o       = (state_q != S_IDLE);
    done_o       = (state_q == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q     <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      daddr_q <= '0;
      aaddr_q <= '0;
    end else if (clear_i) begin
      r_q     <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      daddr_q <= '0;
      aaddr_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start_i) r_q <= '0;
        S_SCAN: begin
          if (r_q != LAST) begin
            if (cur_n == '0) begin
              r_q <= r_q + 1'b1;
            end else begin
              len_q   <= cur_n;
              daddr_q <= cur_daddr;
              aaddr_q <= cur_aaddr;
            end
          end
        end
        S_REQ:  cnt_q <= '0;
        S_XFER: begin
          if (last_beat) r_q   <= r_q + 1'b1;
          else if (beat) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Write stage: one cycle behind the accepted beat; frozen as a whole while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_q   <= 1'b0;
      wr_sel_q  <= 3'd7;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (clear_i) begin
      wr_en_q   <= 1'b0;
      wr_sel_q  <= 3'd7;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (!stall) begin
      wr_en_q <= beat;
      if (beat) begin
        wr_sel_q  <= 3'(r_q);
        wr_addr_q <= aaddr_q + AW'(cnt_q);
        wr_data_q <= data_i;
      end else begin
        wr_sel_q  <= 3'd7;
      end
    end
  end

  assign mem_wr_en_o = wr_en_q;
  assign mem_sel_o   = wr_sel_q;
  assign mem_addr_o  = wr_addr_q;
  assign mem_wdata_o = wr_data_q;

endmodule

// File: tb/tb_panda_mem_load_seq.sv
// Directed self-checking bench for panda_mem_load_seq; stall scenario runs only
// when PANDA_LOAD_SEQ_STALL_EN is defined.
module tb_panda_mem_load_seq;
  localparam int unsigned DW = 32, AW = 16, NW = 16, NREG = 7;

  typedef logic [50:0] wr_t;   // {sel[2:0], addr[15:0], data[31:0]}
  typedef logic [47:0] rq_t;   // {addr[31:0], len[15:0]}

  logic                clk = 1'b0;
  logic                rst_ni = 1'b0;
  logic                clear_i = 1'b0;
  logic                start_i = 1'b0;
  logic [NREG*NW-1:0]  region_n_i = '0;
  logic [NREG*32-1:0]  region_daddr_i = '0;
  logic [NREG*AW-1:0]  region_aaddr_i = '0;
  logic                src_req_o;
  logic [31:0]         src_addr_o;
  logic [NW-1:0]       src_len_o;
  logic [DW-1:0]       data_i = '0;
  logic                data_valid_i = 1'b0;
  logic                data_ready_o;
  logic                mem_stall_i = 1'b0;
  logic [2:0]          mem_sel_o;
  logic                mem_wr_en_o;
  logic [AW-1:0]       mem_addr_o;
  logic [DW-1:0]       mem_wdata_o;
  logic                busy_o;
  logic                done_o;

  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  last_wr_cyc = 0;
  int  beats = 0;
  logic last_ready = 1'b0;
  logic last_done = 1'b0;
  wr_t wlog[$];
  rq_t rlog[$];
  wr_t exp_w[$];

  always #5 clk = ~clk;

  panda_mem_load_seq #(.DW(DW), .AW(AW), .NW(NW), .NREG(NREG)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .region_n_i     (region_n_i),
    .region_daddr_i (region_daddr_i),
    .region_aaddr_i (region_aaddr_i),
    .src_req_o      (src_req_o),
    .src_addr_o     (src_addr_o),
    .src_len_o      (src_len_o),
    .data_i         (data_i),
    .data_valid_i   (data_valid_i),
    .data_ready_o   (data_ready_o),
`ifdef PANDA_LOAD_SEQ_STALL_EN
    .mem_stall_i    (mem_stall_i),
`endif
    .mem_sel_o      (mem_sel_o),
    .mem_wr_en_o    (mem_wr_en_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  // Passive log of committed writes, streamer requests and done pulses.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_ni) begin
      if (mem_wr_en_o && !mem_stall_i) begin
        wlog.push_back({mem_sel_o, mem_addr_o, mem_wdata_o});
        last_wr_cyc = cyc;
      end
      if (src_req_o) rlog.push_back({src_addr_o, src_len_o});
      if (done_o) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag, input int mark);
    check({tag, "_nwr"}, 64'(wlog.size() - mark), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) begin
      if (mark + i < wlog.size())
        check($sformatf("%s_wr%0d", tag, i), 64'(wlog[mark + i]), 64'(exp_w[i]));
    end
  endtask

  // One clock cycle: inputs applied just after a rising edge, outputs sampled at the falling edge.
  task automatic step(input logic v, input logic st, input logic cl, input logic s);
    logic acc;
    data_valid_i = v;
    start_i      = st;
    clear_i      = cl;
    mem_stall_i  = s;
    @(negedge clk);
    last_ready = data_ready_o;
    last_done  = done_o;
    acc = v && data_ready_o && !cl;
    @(posedge clk);
    #1;
    if (acc) begin
      data_i = data_i + 1;
      beats++;
    end
    start_i = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic set_region(input int r, input logic [15:0] n, input logic [31:0] da,
                            input logic [15:0] aa);
    region_n_i[r*NW +: NW]     = n;
    region_daddr_i[r*32 +: 32] = da;
    region_aaddr_i[r*AW +: AW] = aa;
  endtask

  initial begin
    int wm, rm, dm, done_at, stall_left;
    logic s;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sel", 64'(mem_sel_o), 64'd7);
    check("rst_wr_en", 64'(mem_wr_en_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_req", 64'(src_req_o), 64'd0);
    check("rst_ready", 64'(data_ready_o), 64'd0);
    check("rst_addr", 64'(src_addr_o), 64'd0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("idle_ready", 64'(last_ready), 64'd0);

    // Two short regions, valid held high throughout.
    set_region(0, 16'd2, 32'h0000_1000, 16'h0010);
    set_region(1, 16'd1, 32'h0000_2000, 16'h0040);
    data_i = 32'hCAFE_0000;
    wm = wlog.size(); rm = rlog.size(); dm = done_cnt;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_w.delete();
    exp_w.push_back({3'd0, 16'h0010, 32'hCAFE_0000});
    exp_w.push_back({3'd0, 16'h0011, 32'hCAFE_0001});
    exp_w.push_back({3'd1, 16'h0040, 32'hCAFE_0002});
    check_writes("t1", wm);
    check("t1_nreq", 64'(rlog.size() - rm), 64'd2);
    if (rlog.size() >= rm + 2) begin
      check("t1_req0", 64'(rlog[rm]), 64'({32'h0000_1000, 16'd2}));
      check("t1_req1", 64'(rlog[rm + 1]), 64'({32'h0000_2000, 16'd1}));
    end
    check("t1_ndone", 64'(done_cnt - dm), 64'd1);
    check("t1_order", 64'(done_cyc > last_wr_cyc), 64'd1);
    check("t1_busy", 64'(busy_o), 64'd0);

    // All regions empty: done exactly NREG+2 cycles after start.
    for (int r = 0; r < NREG; r++) set_region(r, 16'd0, 32'h0, 16'h0);
    wm = wlog.size(); rm = rlog.size(); dm = done_cnt;
    done_at = -1;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (last_done && done_at < 0) done_at = k;
    end
    check("t2_done_at", 64'(done_at), 64'd9);
    check("t2_ndone", 64'(done_cnt - dm), 64'd1);
    check("t2_nreq", 64'(rlog.size() - rm), 64'd0);
    check("t2_nwr", 64'(wlog.size() - wm), 64'd0);

    // Last region only, valid toggling.
    set_region(6, 16'd3, 32'h0000_6000, 16'h0200);
    data_i = 32'h3000_0000;
    wm = wlog.size(); rm = rlog.size(); dm = done_cnt;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) step(1'(k % 2), 1'b0, 1'b0, 1'b0);
    exp_w.delete();
    exp_w.push_back({3'd6, 16'h0200, 32'h3000_0000});
    exp_w.push_back({3'd6, 16'h0201, 32'h3000_0001});
    exp_w.push_back({3'd6, 16'h0202, 32'h3000_0002});
    check_writes("t3", wm);
    check("t3_nreq", 64'(rlog.size() - rm), 64'd1);
    check("t3_ndone", 64'(done_cnt - dm), 64'd1);
    check("t3_order", 64'(done_cyc > last_wr_cyc), 64'd1);

    // Clear after two of five beats of region 4, then a full restart.
    set_region(6, 16'd0, 32'h0, 16'h0);
    set_region(0, 16'd1, 32'h0000_0100, 16'h0020);
    set_region(4, 16'd5, 32'h0000_0400, 16'h0300);
    data_i = 32'h4000_0000;
    beats = 0;
    wm = wlog.size(); dm = done_cnt;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 40 && beats < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t4_beats", 64'(beats), 64'd3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("t4_busy", 64'(busy_o), 64'd0);
    check("t4_sel", 64'(mem_sel_o), 64'd7);
    check("t4_wr_en", 64'(mem_wr_en_o), 64'd0);
    check("t4_ready", 64'(data_ready_o), 64'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t4_nodone", 64'(done_cnt - dm), 64'd0);
    exp_w.delete();
    exp_w.push_back({3'd0, 16'h0020, 32'h4000_0000});
    exp_w.push_back({3'd4, 16'h0300, 32'h4000_0001});
    exp_w.push_back({3'd4, 16'h0301, 32'h4000_0002});
    check_writes("t4a", wm);
    wm = wlog.size(); dm = done_cnt;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_w.delete();
    exp_w.push_back({3'd0, 16'h0020, 32'h4000_0003});
    for (int i = 0; i < 5; i++) exp_w.push_back({3'd4, 16'h0300 + 16'(i), 32'h4000_0004 + 32'(i)});
    check_writes("t4b", wm);
    check("t4_ndone", 64'(done_cnt - dm), 64'd1);

    // Address wraps at the top of the accelerator memory.
    set_region(4, 16'd0, 32'h0, 16'h0);
    set_region(0, 16'd2, 32'h0000_0500, 16'hFFFF);
    data_i = 32'h5000_0000;
    wm = wlog.size();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_w.delete();
    exp_w.push_back({3'd0, 16'hFFFF, 32'h5000_0000});
    exp_w.push_back({3'd0, 16'h0000, 32'h5000_0001});
    check_writes("t5", wm);

`ifdef PANDA_LOAD_SEQ_STALL_EN
    // Three stalled cycles in the middle of a region.
    set_region(0, 16'd0, 32'h0, 16'h0);
    set_region(2, 16'd6, 32'h0000_0800, 16'h0080);
    data_i = 32'h6000_0000;
    beats = 0;
    stall_left = 3;
    wm = wlog.size(); dm = done_cnt;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      s = (beats == 2) && (stall_left > 0);
      step(1'b1, 1'b0, 1'b0, s);
      if (s) begin
        check($sformatf("t6_ready_stall%0d", stall_left), 64'(last_ready), 64'd0);
        stall_left--;
      end
    end
    exp_w.delete();
    for (int i = 0; i < 6; i++) exp_w.push_back({3'd2, 16'h0080 + 16'(i), 32'h6000_0000 + 32'(i)});
    check_writes("t6", wm);
    check("t6_ndone", 64'(done_cnt - dm), 64'd1);
`else
    stall_left = 0;
    s = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
